// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding,
// default sizing constants and a one-hot to binary index helper.
package mult_arb_pkg;

    // Controller states; 3-bit encoding so the debug port has a fixed width
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    // Largest supported requester count; sizes the index helper below
    localparam int MAX_REQ = 8;

    // Converts a one-hot vector (zero-extended to MAX_REQ bits) into the
    // binary index of its set bit. OR-ing the indices of set bits is exact
    // for a one-hot input and keeps the logic a flat OR tree.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational request arbiter for the shared multiplier.
// Default: round robin, search starts at ptr_i and wraps upward.
// With MULT_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins
// and ptr_i is ignored.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Pointer has no meaning in fixed-priority mode
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

    // Pick the first asserted request at or above the start index, with wrap
    always_comb begin
        int   start;
        int   idx;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = int'(ptr_i);
`endif
        for (int i = 0; i < N_REQ; i++) begin
            idx = (start + i) % N_REQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier datapath among N_REQ requesters.
// Arbitrates in IDLE, holds a one-hot grant plus binary select for the
// whole job, sequences Load/Sh/Ad from a bit counter and returns a
// one-cycle Done pulse to the winner.
// Optional build macro: MULT_ARB_FIXED_PRIO_EN (fixed priority, no pointer).
//
// Handshake: a requester raises Req and holds it until it sees its Done
// bit; Req changes after the grant edge are ignored until the next IDLE.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SEL_W = $clog2(N_REQ)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [N_REQ-1:0] Req,
    input  logic             M,
    output logic [N_REQ-1:0] Gnt,
    output logic [SEL_W-1:0] Sel,
    output logic             Load,
    output logic             Sh,
    output logic             Ad,
    output logic [N_REQ-1:0] Done,
    output logic             Idle,
    output state_e           dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic               load_q;
    logic [N_REQ-1:0]   done_q;
    logic               idle_q;
    logic [SEL_W-1:0]   ptr;
    logic [N_REQ-1:0]   win;
    logic               last_shift;

    mult_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i (Req),
        .ptr_i (ptr),
        .gnt_o (win)
    );

    // The step that is currently shifting is the WIDTH-th one
    assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SEL_W-1:0] ptr_q;

    // Round-robin pointer moves just past the requester that finished
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q <= '0;
        end else if (state_q == ST_DONE) begin
            ptr_q <= (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    assign ptr = ptr_q;
`endif

    // Controller FSM with registered grant, select, Load, Done and Idle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            load_q  <= 1'b0;
            done_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|Req) begin
                        gnt_q   <= win;
                        sel_q   <= SEL_W'(onehot_to_idx(MAX_REQ'(win)));
                        load_q  <= 1'b1;
                        idle_q  <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (M) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_shift) begin
                            done_q  <= gnt_q;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_shift) begin
                        done_q  <= gnt_q;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    sel_q   <= '0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    gnt_q   <= '0;
                    sel_q   <= '0;
                    load_q  <= 1'b0;
                    done_q  <= '0;
                    idle_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath strobes: CHECK adds or shifts depending on the live M bit
    always_comb begin
        Ad = 1'b0;
        Sh = 1'b0;
        if (state_q == ST_CHECK) begin
            Ad = M;
            Sh = !M;
        end else if (state_q == ST_SHIFT) begin
            Sh = 1'b1;
        end
    end

    assign Gnt         = gnt_q;
    assign Sel         = sel_q;
    assign Load        = load_q;
    assign Done        = done_q;
    assign Idle        = idle_q;
    assign dbg_state_o = state_q;

endmodule
